eight_bit_wallace_tree_bank: RTL and testbench

EIGHT_BIT_WALLACE_TREE_BANK -- requirements
Module: eight_bit_wallace_tree_bank

---
 rtl/eight_bit_wallace_tree_bank_pkg.sv | 43 ++++
 rtl/eight_bit_wallace_tree_bank_if.sv | 23 ++
 rtl/eight_bit_wallace_tree_bank_full_adder.sv | 11 +
 rtl/eight_bit_wallace_tree_bank.sv | 123 ++++++++++++
 tb/tb_eight_bit_wallace_tree_bank.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/eight_bit_wallace_tree_bank_pkg.sv
// Shared widths, result payload and reduction-tree wiring tables.
package eight_bit_wallace_tree_bank_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned APPROX_LO = 8;
  localparam int unsigned N_CSA     = 6;
  localparam int unsigned POOL_N    = 8 + 2 * N_CSA;

  typedef struct packed {
    logic [PROD_W-1:0] exact;
    logic [PROD_W-1:0] approx;
    logic [PROD_W-1:0] arr;
    logic [PROD_W-1:0] err;
  } result_t;

  // Row pool: 0..7 are partial-product rows, CSA c writes sum to 8+2c and carry to 9+2c.
  // Wallace grouping 8 -> 6 -> 4 -> 3 -> 2 rows; rows 18/19 feed the final adder.
  function automatic int unsigned csa_src(input int unsigned c, input int unsigned k);
    int unsigned r;
    r = 0;
    case (c)
      0: r = k;
      1: r = 3 + k;
      2: r = 8 + k;
      3: r = (k == 0) ? 11 : ((k == 1) ? 6 : 7);
      4: r = 12 + k;
      5: r = (k == 0) ? 16 : ((k == 1) ? 17 : 15);
      default: r = 0;
    endcase
    return r;
  endfunction

  // Multiplicand bits of row j whose weight lands in the upper (exact) region.
  function automatic logic [OP_W-1:0] approx_mask(input int unsigned j);
    logic [OP_W-1:0] m;
    for (int unsigned i = 0; i < OP_W; i++) begin
      m[i] = ((i + j) >= APPROX_LO);
    end
    return m;
  endfunction

endpackage

// File: rtl/eight_bit_wallace_tree_bank_if.sv
// Operand/result bus between a driver and the multiplier bank.
interface eight_bit_wallace_tree_bank_if;
  import eight_bit_wallace_tree_bank_pkg::*;

  logic              in_valid;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic              out_valid;
  logic [PROD_W-1:0] S_tree_exact;
  logic [PROD_W-1:0] S_tree_approx;
  logic [PROD_W-1:0] S_array;
  logic [PROD_W-1:0] err_mag;

  modport master (
    output in_valid, A, B,
    input  out_valid, S_tree_exact, S_tree_approx, S_array, err_mag
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, S_tree_exact, S_tree_approx, S_array, err_mag
  );
endinterface

// File: rtl/eight_bit_wallace_tree_bank_full_adder.sv
// One-bit 3:2 compressor shared by every reduction and ripple row.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/eight_bit_wallace_tree_bank.sv
// Exact Wallace, approximate Wallace and array 8x8 multipliers with one registered output stage.
module eight_bit_wallace_tree_bank
  import eight_bit_wallace_tree_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  eight_bit_wallace_tree_bank_if.slave bus
);

  localparam int unsigned N_ADD = 9;

  logic [OP_W-1:0]   w_a;
  logic [OP_W-1:0]   w_b;
  logic [PROD_W-1:0] w_pool  [2][POOL_N];
  logic [PROD_W-1:0] w_add_a [N_ADD];
  logic [PROD_W-1:0] w_add_b [N_ADD];
  logic [PROD_W-1:0] w_add_s [N_ADD];
  logic [APPROX_LO-1:0] w_lo;
  result_t           w_res;
  result_t           r_res;
  logic              r_out_valid;

  assign w_a = bus.A;
  assign w_b = bus.B;

  // Partial-product rows: tree 0 keeps all bits, tree 1 keeps only the upper-region bits.
  for (genvar j = 0; j < OP_W; j++) begin : g_pp
    localparam logic [OP_W-1:0] MASK = approx_mask(j);
    assign w_pool[0][j] = PROD_W'(w_a & {OP_W{w_b[j]}}) << j;
    assign w_pool[1][j] = PROD_W'(w_a & MASK & {OP_W{w_b[j]}}) << j;
  end

  // Carry-save reduction stages for both trees.
  for (genvar t = 0; t < 2; t++) begin : g_tree
    for (genvar c = 0; c < N_CSA; c++) begin : g_csa
      localparam int unsigned X = csa_src(c, 0);
      localparam int unsigned Y = csa_src(c, 1);
      localparam int unsigned Z = csa_src(c, 2);
      logic [PROD_W-1:0] w_sum;
      logic [PROD_W-2:0] w_co;
      for (genvar k = 0; k < PROD_W - 1; k++) begin : g_bit
        full_adder u_fa (
          .a    (w_pool[t][X][k]),
          .b    (w_pool[t][Y][k]),
          .cin  (w_pool[t][Z][k]),
          .sum  (w_sum[k]),
          .cout (w_co[k])
        );
      end
      // Top-bit carry would be weight 2^16, impossible for an 8x8 product.
      assign w_sum[PROD_W-1] = w_pool[t][X][PROD_W-1] ^ w_pool[t][Y][PROD_W-1] ^ w_pool[t][Z][PROD_W-1];
      assign w_pool[t][8 + 2 * c] = w_sum;
      assign w_pool[t][9 + 2 * c] = {w_co, 1'b0};
    end
  end

  // Ripple adders: 0..6 form the shift-and-add array, 7/8 are the tree carry-propagate adders.
  for (genvar n = 0; n < N_ADD; n++) begin : g_add
    logic [PROD_W-1:0] w_c;
    if (n == 0) begin : g_first
      assign w_add_a[n] = w_pool[0][0];
      assign w_add_b[n] = w_pool[0][1];
    end else if (n < OP_W - 1) begin : g_row
      assign w_add_a[n] = w_add_s[n-1];
      assign w_add_b[n] = w_pool[0][n+1];
    end else begin : g_cpa
      assign w_add_a[n] = w_pool[n-(OP_W-1)][POOL_N-2];
      assign w_add_b[n] = w_pool[n-(OP_W-1)][POOL_N-1];
    end
    assign w_c[0] = 1'b0;
    for (genvar k = 0; k < PROD_W - 1; k++) begin : g_bit
      full_adder u_fa (
        .a    (w_add_a[n][k]),
        .b    (w_add_b[n][k]),
        .cin  (w_c[k]),
        .sum  (w_add_s[n][k]),
        .cout (w_c[k+1])
      );
    end
    assign w_add_s[n][PROD_W-1] = w_add_a[n][PROD_W-1] ^ w_add_b[n][PROD_W-1] ^ w_c[PROD_W-1];
  end

  // Approximate lower columns: each output bit is the OR of its column's partial products.
  always_comb begin
    w_lo = '0;
    for (int unsigned i = 0; i < OP_W; i++) begin
      for (int unsigned j = 0; j < OP_W; j++) begin
        if ((i + j) < APPROX_LO) begin
          w_lo[3'(i + j)] = w_lo[3'(i + j)] | (w_a[i] & w_b[j]);
        end
      end
    end
  end

  // Upper-region sum has a zero low byte, so OR-ing in the lower bits is a concatenation.
  always_comb begin
    w_res        = '0;
    w_res.exact  = w_add_s[OP_W-1];
    w_res.approx = w_add_s[OP_W] | PROD_W'(w_lo);
    w_res.arr    = w_add_s[OP_W-2];
    w_res.err    = w_res.exact - w_res.approx;
  end

  // Output stage: capture on in_valid, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_res <= w_res;
      end
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.S_tree_exact  = r_res.exact;
  assign bus.S_tree_approx = r_res.approx;
  assign bus.S_array       = r_res.arr;
  assign bus.err_mag       = r_res.err;

endmodule

// File: tb/tb_eight_bit_wallace_tree_bank.sv
// Scoreboard bench for the 8x8 multiplier bank.
module tb_eight_bit_wallace_tree_bank;
  import eight_bit_wallace_tree_bank_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  result_t exp_q[$];
  result_t last_exp;
  logic    exp_ov;

  eight_bit_wallace_tree_bank_if bus ();

  eight_bit_wallace_tree_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product by multiplication, approximation from column rules.
  function automatic result_t model(input logic [7:0] a, input logic [7:0] b);
    result_t r;
    int unsigned lo, hi, ex;
    ex = 32'(a) * 32'(b);
    lo = 0;
    hi = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j]) begin
          if (i + j < 8) lo = lo | (32'd1 << (i + j));
          else           hi = hi + (32'd1 << (i + j));
        end
    r.exact  = 16'(ex);
    r.arr    = 16'(ex);
    r.approx = 16'(hi + lo);
    r.err    = 16'(ex - (hi + lo));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic v);
    @(posedge clk);
    #1;
    bus.A = a;
    bus.B = b;
    bus.in_valid = v;
    if (v) exp_q.push_back(model(a, b));
  endtask

  task automatic send_exp(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ex, input logic [15:0] ap);
    result_t r;
    @(posedge clk);
    #1;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    r.exact  = ex;
    r.arr    = ex;
    r.approx = ap;
    r.err    = ex - ap;
    exp_q.push_back(r);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ov"},     32'(bus.out_valid),     32'd0);
    chk({tag, "_exact"},  32'(bus.S_tree_exact),  32'd0);
    chk({tag, "_approx"}, 32'(bus.S_tree_approx), 32'd0);
    chk({tag, "_array"},  32'(bus.S_array),       32'd0);
    chk({tag, "_err"},    32'(bus.err_mag),       32'd0);
  endtask

  // Expected out_valid: the in_valid seen at the previous edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_ov <= 1'b0;
    else        exp_ov <= bus.in_valid;
  end

  // Monitor: pop and compare on valid output, check hold otherwise.
  always @(negedge clk) begin
    result_t e;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
      end
    end
    chk("exact",  32'(bus.S_tree_exact),  32'(last_exp.exact));
    chk("approx", 32'(bus.S_tree_approx), 32'(last_exp.approx));
    chk("array",  32'(bus.S_array),       32'(last_exp.arr));
    chk("err",    32'(bus.err_mag),       32'(last_exp.err));
    if (bus.S_tree_approx > bus.S_tree_exact) chk("approx_le_exact", 32'(bus.S_tree_approx), 32'(bus.S_tree_exact));
  end

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    last_exp = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    check_zero("reset");
    #11;
    rst_n = 1'b1;

    // Directed corner cases with fixed expected values.
    send_exp(8'd0,   8'd0,   16'd0,     16'd0);
    send_exp(8'd255, 8'd255, 16'd65025, 16'd63487);
    send_exp(8'd3,   8'd3,   16'd9,     16'd7);
    send_exp(8'd3,   8'd5,   16'd15,    16'd15);
    send_exp(8'd16,  8'd16,  16'd256,   16'd256);

    // Valid toggling 1,0,1: hold during the gap.
    send(8'd200, 8'd77, 1'b1);
    send(8'd9,   8'd9,  1'b0);
    send(8'd13,  8'd250, 1'b1);
    send(8'd0,   8'd0,  1'b0);

    // Random traffic with a mid-stream asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        last_exp = '0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    end

    // Exhaustive sweep: A steps every cycle, B steps on A wrap.
    for (int n = 0; n < 65536; n++) begin
      send(8'(n), 8'(n >> 8), 1'b1);
    end

    // Drain and confirm every expectation was consumed.
    for (int n = 0; n < 3; n++) send(8'd0, 8'd0, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
